// File: rtl/dlx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dlx_pkg : shared types and encodings for the DLX sequencer                  |
// | Rev 1.0 : initial release                                                   |
// +-----------------------------------------------------------------------------+
package dlx_pkg;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,  ALU_ADD  = 4'd1,  ALU_SUB  = 4'd2,  ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,  ALU_XOR  = 4'd5,  ALU_SLL  = 4'd6,  ALU_SRL  = 4'd7,
    ALU_BEQZ = 4'd8,  ALU_BNEZ = 4'd9,  ALU_SEQ  = 4'd10, ALU_SLE  = 4'd11,
    ALU_SLT  = 4'd12, ALU_SNE  = 4'd13, ALU_SRA  = 4'd14, ALU_PC4  = 4'd15
  } alu_op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQZ  = 6'h04;
  localparam logic [5:0] OPC_BNEZ  = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SUBI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LHI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h04;
  localparam logic [5:0] FN_SRL = 6'h06;
  localparam logic [5:0] FN_SRA = 6'h07;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SEQ = 6'h28;
  localparam logic [5:0] FN_SNE = 6'h29;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLE = 6'h2C;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_DECODE = 4'd1,
    ST_PCINC  = 4'd2,
    ST_PCWR   = 4'd3,
    ST_EXEC   = 4'd4,
    ST_MEM    = 4'd5,
    ST_WB     = 4'd6,
    ST_BRADD  = 4'd7,
    ST_BRWR   = 4'd8
  } seq_state_e;

  typedef enum logic [2:0] {
    CL_ALU     = 3'd0,
    CL_LOAD    = 3'd1,
    CL_STORE   = 3'd2,
    CL_BRANCH  = 3'd3,
    CL_JUMP    = 3'd4,
    CL_ILLEGAL = 3'd5
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    alu_op_e      op;
    logic         op2_imm;
    logic         imm_sext;
    logic [4:0]   rd;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/dlx_seq_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dlx_seq_ctrl_if : instruction, ALU, PC, register-file and memory controls   |
// | Rev 1.0 : initial release                                                   |
// +-----------------------------------------------------------------------------+
interface dlx_seq_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        rf_we;
  logic        wb_sel;
  logic        alu_ex;
  logic [3:0]  alu_op;
  logic        op1_sel;
  logic [1:0]  op2_sel;
  logic        imm_sext;
  logic        pc_we;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ack;
  logic        err;
  logic [31:0] retired;

  modport master (
    input  instr_valid, instr, mem_ack,
    output instr_ready, rs1_addr, rs2_addr, rd_addr, rf_we, wb_sel, alu_ex,
           alu_op, op1_sel, op2_sel, imm_sext, pc_we, mem_rd, mem_wr, err, retired
  );

  modport slave (
    output instr_valid, instr, mem_ack,
    input  instr_ready, rs1_addr, rs2_addr, rd_addr, rf_we, wb_sel, alu_ex,
           alu_op, op1_sel, op2_sel, imm_sext, pc_we, mem_rd, mem_wr, err, retired
  );
endinterface
`default_nettype wire

// File: rtl/dlx_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dlx_decode : combinational DLX instruction classifier and ALU-op mapper     |
// | Rev 1.0 : initial release                                                   |
// +-----------------------------------------------------------------------------+
module dlx_decode
  import dlx_pkg::*;
#(
  parameter int IMM_W = 16
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] opcode;
  logic [5:0] func;
  logic [4:0] rd_r;
  logic [4:0] rd_i;
  logic       unused_fields;

  assign opcode = instr[31:26];
  assign func   = instr[5:0];
  assign rd_r   = instr[15:11];
  // I-type destination sits directly above the immediate field
  assign rd_i   = instr[IMM_W +: 5];
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    dec.cls      = CL_ILLEGAL;
    dec.op       = ALU_NOP;
    dec.op2_imm  = 1'b0;
    dec.imm_sext = 1'b1;
    dec.rd       = 5'd0;
    case (opcode)
      OPC_RTYPE: begin
        dec.cls = CL_ALU;
        dec.rd  = rd_r;
        case (func)
          FN_ADD:  dec.op = ALU_ADD;
          FN_SUB:  dec.op = ALU_SUB;
          FN_AND:  dec.op = ALU_AND;
          FN_OR:   dec.op = ALU_OR;
          FN_XOR:  dec.op = ALU_XOR;
          FN_SLL:  dec.op = ALU_SLL;
          FN_SRL:  dec.op = ALU_SRL;
          FN_SRA:  dec.op = ALU_SRA;
          FN_SEQ:  dec.op = ALU_SEQ;
          FN_SNE:  dec.op = ALU_SNE;
          FN_SLT:  dec.op = ALU_SLT;
          FN_SLE:  dec.op = ALU_SLE;
          default: begin
            dec.cls = CL_ILLEGAL;
            dec.rd  = 5'd0;
          end
        endcase
      end
      OPC_ADDI: begin dec.cls = CL_ALU; dec.op2_imm = 1'b1; dec.rd = rd_i; dec.op = ALU_ADD; end
      OPC_SUBI: begin dec.cls = CL_ALU; dec.op2_imm = 1'b1; dec.rd = rd_i; dec.op = ALU_SUB; end
      OPC_ANDI: begin
        dec.cls = CL_ALU; dec.op2_imm = 1'b1; dec.rd = rd_i; dec.op = ALU_AND; dec.imm_sext = 1'b0;
      end
      OPC_ORI: begin
        dec.cls = CL_ALU; dec.op2_imm = 1'b1; dec.rd = rd_i; dec.op = ALU_OR; dec.imm_sext = 1'b0;
      end
      OPC_XORI: begin
        dec.cls = CL_ALU; dec.op2_imm = 1'b1; dec.rd = rd_i; dec.op = ALU_XOR; dec.imm_sext = 1'b0;
      end
      OPC_LHI: begin
        dec.cls = CL_ALU; dec.op2_imm = 1'b1; dec.rd = rd_i; dec.op = ALU_NOP; dec.imm_sext = 1'b0;
      end
      OPC_LW:   begin dec.cls = CL_LOAD;   dec.op2_imm = 1'b1; dec.rd = rd_i; dec.op = ALU_ADD; end
      OPC_SW:   begin dec.cls = CL_STORE;  dec.op2_imm = 1'b1; dec.op = ALU_ADD; end
      OPC_BEQZ: begin dec.cls = CL_BRANCH; dec.op2_imm = 1'b1; dec.op = ALU_BEQZ; end
      OPC_BNEZ: begin dec.cls = CL_BRANCH; dec.op2_imm = 1'b1; dec.op = ALU_BNEZ; end
      OPC_J:    begin dec.cls = CL_JUMP;   dec.op2_imm = 1'b1; end
      default:  dec.cls = CL_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dlx_seq_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | dlx_seq_ctrl : multi-cycle DLX instruction sequencer (ALU/PC/RF/memory)     |
// | Optional retired-instruction counter: define DLX_PERF_CNT_EN                |
// | Rev 1.0 : initial release                                                   |
// +-----------------------------------------------------------------------------+
module dlx_seq_ctrl
  import dlx_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int MEM_TO = 255
) (
  input  logic             clk,
  input  logic             rst,
  dlx_seq_ctrl_if.master   bus
);

  localparam int                CNT_W    = $clog2(MEM_TO + 1);
  localparam logic [CNT_W-1:0]  MEM_LAST = CNT_W'(MEM_TO - 1);

  seq_state_e       state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  dec_t             dec;

  logic       instr_ready;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic       rf_we, wb_sel, alu_ex, op1_sel, imm_sext, pc_we, mem_rd, mem_wr, err;
  logic [3:0] alu_op;
  logic [1:0] op2_sel;
  logic       retire;

  dlx_decode #(.IMM_W(IMM_W)) u_decode (
    .instr (instr_q),
    .dec   (dec)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    mem_cnt_d   = '0;
    instr_ready = 1'b0;
    rs1_addr    = 5'd0;
    rs2_addr    = 5'd0;
    rd_addr     = 5'd0;
    rf_we       = 1'b0;
    wb_sel      = 1'b0;
    alu_ex      = 1'b0;
    alu_op      = ALU_NOP;
    op1_sel     = 1'b0;
    op2_sel     = 2'd0;
    imm_sext    = 1'b0;
    pc_we       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    err         = 1'b0;
    retire      = 1'b0;

    if (state_q != ST_IDLE) begin
      rs1_addr = instr_q[25:21];
      rs2_addr = instr_q[20:16];
    end

    case (state_q)
      ST_IDLE: begin
        // reset holds the FSM in IDLE, but no instruction may be taken then
        instr_ready = !rst;
        if (bus.instr_valid && !rst) begin
          instr_d = bus.instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.cls == CL_ILLEGAL) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PCINC;
        end
      end
      ST_PCINC: begin
        alu_ex  = 1'b1;
        alu_op  = ALU_PC4;
        op1_sel = 1'b1;
        state_d = ST_PCWR;
      end
      ST_PCWR: begin
        pc_we   = 1'b1;
        state_d = (dec.cls == CL_JUMP) ? ST_BRADD : ST_EXEC;
      end
      ST_EXEC: begin
        alu_ex   = 1'b1;
        alu_op   = dec.op;
        op2_sel  = {1'b0, dec.op2_imm};
        imm_sext = dec.imm_sext;
        case (dec.cls)
          CL_ALU:             state_d = ST_WB;
          CL_LOAD, CL_STORE:  state_d = ST_MEM;
          CL_BRANCH:          state_d = ST_BRADD;
          default:            state_d = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        mem_rd    = (dec.cls == CL_LOAD);
        mem_wr    = (dec.cls == CL_STORE);
        mem_cnt_d = mem_cnt_q + CNT_W'(1);
        // an ack on the final permitted cycle still completes the access
        if (bus.mem_ack) begin
          if (dec.cls == CL_LOAD) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (mem_cnt_q == MEM_LAST) begin
          err     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        rd_addr = dec.rd;
        rf_we   = (dec.rd != 5'd0);
        wb_sel  = (dec.cls == CL_LOAD);
        retire  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_BRADD: begin
        alu_ex   = 1'b1;
        alu_op   = ALU_ADD;
        op1_sel  = 1'b1;
        op2_sel  = (dec.cls == CL_JUMP) ? 2'd1 : 2'd2;
        imm_sext = dec.imm_sext;
        state_d  = ST_BRWR;
      end
      ST_BRWR: begin
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      mem_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

`ifdef DLX_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q + (retire ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign bus.retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign bus.retired   = '0;
`endif

  assign bus.instr_ready = instr_ready;
  assign bus.rs1_addr    = rs1_addr;
  assign bus.rs2_addr    = rs2_addr;
  assign bus.rd_addr     = rd_addr;
  assign bus.rf_we       = rf_we;
  assign bus.wb_sel      = wb_sel;
  assign bus.alu_ex      = alu_ex;
  assign bus.alu_op      = alu_op;
  assign bus.op1_sel     = op1_sel;
  assign bus.op2_sel     = op2_sel;
  assign bus.imm_sext    = imm_sext;
  assign bus.pc_we       = pc_we;
  assign bus.mem_rd      = mem_rd;
  assign bus.mem_wr      = mem_wr;
  assign bus.err         = err;

endmodule
`default_nettype wire
